// File: rtl/instr_fetch.sv
// PC fetch stage: issues program-memory reads, captures the returning word and hands it
// to the decoder over valid/ready, with a one-entry skid and branch flush.
// Optional FETCH_PERF_CNT_EN adds fetch_cnt/stall_cnt performance counters.
module instr_fetch #(
  parameter int ADDR_W            = 10,
  parameter int DATA_W            = 14,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              iclk,
  input  logic              irst,
  input  logic              fetch_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              branch_valid,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       fetch_cnt,
  output logic [31:0]       stall_cnt
`endif
);

  logic [ADDR_W-1:0] pc_q, req_pc_q, skid_pc;
  logic [DATA_W-1:0] skid_data;
  logic              run_q, req_q, skid_valid;
  logic              issue, consume, out_stall;

  assign consume   = instr_valid & instr_ready;
  assign out_stall = instr_valid & ~instr_ready;
  assign mem_addr  = branch_valid ? branch_target : pc_q;

  // Hold off issue whenever the word already in flight might have nowhere to land.
  assign issue = run_q & (branch_valid |
                 (fetch_en & ~skid_valid & ~(req_q & out_stall)));
  assign mem_rd_en = issue;

  always_ff @(posedge iclk or negedge irst) begin
    if (!irst) begin
      pc_q        <= ADDR_W'(RESET_PC);
      run_q       <= 1'b0;
      req_q       <= 1'b0;
      req_pc_q    <= '0;
      skid_valid  <= 1'b0;
      skid_data   <= '0;
      skid_pc     <= '0;
      instr_valid <= 1'b0;
      instr_data  <= '0;
      instr_pc    <= '0;
    end else begin
      run_q <= 1'b1;
      req_q <= issue;
      if (issue) begin
        req_pc_q <= mem_addr;
        pc_q     <= mem_addr + ADDR_W'(1);
      end

      if (branch_valid) begin
        // Redirect: the in-flight word and anything buffered are stale.
        skid_valid  <= 1'b0;
        instr_valid <= 1'b0;
      end else if (skid_valid) begin
        if (consume) begin
          instr_data <= skid_data;
          instr_pc   <= skid_pc;
          skid_valid <= req_q;
          if (req_q) begin
            skid_data <= mem_rdata;
            skid_pc   <= req_pc_q;
          end
        end
      end else if (req_q) begin
        if (!out_stall) begin
          instr_valid <= 1'b1;
          instr_data  <= mem_rdata;
          instr_pc    <= req_pc_q;
        end else begin
          skid_valid <= 1'b1;
          skid_data  <= mem_rdata;
          skid_pc    <= req_pc_q;
        end
      end else if (consume) begin
        instr_valid <= 1'b0;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge iclk or negedge irst) begin
    if (!irst) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (consume)   fetch_cnt <= fetch_cnt + 32'd1;
      if (out_stall) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: registered program-memory model plus per-scenario tasks.
module tb_instr_fetch;

  logic        iclk, irst, fetch_en, branch_valid, instr_ready;
  logic [9:0]  mem_addr, branch_target, instr_pc;
  logic [13:0] mem_rdata, instr_data;
  logic        mem_rd_en, instr_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt, stall_cnt;
`endif

  int errors = 0;
  int checks = 0;

  logic [13:0] mem [0:1023];

  instr_fetch #(.ADDR_W(10), .DATA_W(14), .RESET_PC(0)) dut (
    .iclk(iclk), .irst(irst), .fetch_en(fetch_en),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
    .branch_valid(branch_valid), .branch_target(branch_target),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_data(instr_data), .instr_pc(instr_pc)
`ifdef FETCH_PERF_CNT_EN
    , .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt)
`endif
  );

  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  initial begin
    for (int k = 0; k < 1024; k++) mem[k] = 14'(k + 'h100);
    mem_rdata = '0;
  end

  always @(posedge iclk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

  // Skid overflow must be structurally impossible.
  always @(negedge iclk)
    if (irst && dut.req_q && dut.skid_valid && instr_valid && !instr_ready && !branch_valid) begin
      errors++;
      $display("FAIL skid_overflow: req_q, skid and stalled output all valid at %0t", $time);
    end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge iclk); #1;
  endtask

  task automatic next_word(output logic [9:0] pc, output logic [13:0] d, output bit ok);
    ok = 0; pc = '0; d = '0;
    for (int n = 0; n < 20 && !ok; n++) begin
      if (instr_valid && instr_ready) begin pc = instr_pc; d = instr_data; ok = 1; end
      step();
    end
  endtask

  task automatic test_reset();
    irst = 0; fetch_en = 1; instr_ready = 1; branch_valid = 0; branch_target = '0;
    repeat (2) step();
    checks++;
    if ({instr_valid, instr_pc, instr_data, mem_rd_en} !== {1'b0, 10'd0, 14'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got v=%b pc=%0h d=%0h rd=%b, want all 0", instr_valid, instr_pc, instr_data, mem_rd_en);
    end
    @(negedge iclk); irst = 1; #1;
    checks++;
    if (mem_rd_en !== 1'b0) begin errors++; $display("FAIL first_cycle_no_issue: rd=%b want 0", mem_rd_en); end
    step();
    checks++;
    if ({mem_rd_en, mem_addr} !== {1'b1, 10'd0}) begin
      errors++; $display("FAIL first_issue: rd=%b addr=%0h want 1/0", mem_rd_en, mem_addr);
    end
    step();
    checks++;
    if (instr_valid !== 1'b0) begin errors++; $display("FAIL latency_bubble: v=%b want 0", instr_valid); end
    step();
    checks++;
    if ({instr_valid, instr_pc, instr_data} !== {1'b1, 10'd0, 14'h100}) begin
      errors++; $display("FAIL first_word: v=%b pc=%0h d=%0h want 1/0/100", instr_valid, instr_pc, instr_data);
    end
  endtask

  task automatic test_stream();
    for (int k = 1; k <= 3; k++) begin
      step();
      checks++;
      if ({instr_valid, instr_pc, instr_data} !== {1'b1, 10'(k), 14'(k + 'h100)}) begin
        errors++; $display("FAIL stream_%0d: v=%b pc=%0h d=%0h", k, instr_valid, instr_pc, instr_data);
      end
    end
  endtask

  task automatic test_stall();
    logic [9:0] p; logic [13:0] d; bit ok;
    step();
    checks++;
    if ({instr_valid, instr_pc, instr_data} !== {1'b1, 10'd4, 14'h104}) begin
      errors++; $display("FAIL stall_entry: v=%b pc=%0h d=%0h want 1/4/104", instr_valid, instr_pc, instr_data);
    end
    instr_ready = 0;
    for (int k = 1; k < 5; k++) begin
      step();
      checks++;
      if ({instr_valid, instr_pc, instr_data} !== {1'b1, 10'd4, 14'h104}) begin
        errors++; $display("FAIL stall_hold_%0d: v=%b pc=%0h d=%0h want 1/4/104", k, instr_valid, instr_pc, instr_data);
      end
    end
    checks++;
    if (dut.skid_valid !== 1'b1) begin errors++; $display("FAIL stall_skid: skid_valid=%b want 1", dut.skid_valid); end
    step();
    instr_ready = 1;
    for (int k = 4; k <= 6; k++) begin
      next_word(p, d, ok);
      checks++;
      if (!ok || p !== 10'(k) || d !== 14'(k + 'h100)) begin
        errors++; $display("FAIL stall_release_%0d: ok=%b pc=%0h d=%0h", k, ok, p, d);
      end
    end
  endtask

  task automatic test_branch();
    branch_valid = 1; branch_target = 10'd6; #1;
    checks++;
    if ({mem_rd_en, mem_addr} !== {1'b1, 10'd6}) begin
      errors++; $display("FAIL branch_issue: rd=%b addr=%0h want 1/6", mem_rd_en, mem_addr);
    end
    step(); branch_valid = 0; #1;
    checks++;
    if ({instr_valid, mem_rd_en, mem_addr} !== {1'b0, 1'b1, 10'd7}) begin
      errors++; $display("FAIL branch_flush: v=%b rd=%b addr=%0h want 0/1/7", instr_valid, mem_rd_en, mem_addr);
    end
    step();
    checks++;
    if ({instr_valid, instr_pc, instr_data} !== {1'b1, 10'd6, 14'h106}) begin
      errors++; $display("FAIL branch_target_word: v=%b pc=%0h d=%0h want 1/6/106", instr_valid, instr_pc, instr_data);
    end
    branch_valid = 1; branch_target = 10'h200; #1;
    checks++;
    if ({mem_rd_en, mem_addr} !== {1'b1, 10'h200}) begin
      errors++; $display("FAIL branch2_issue: rd=%b addr=%0h want 1/200", mem_rd_en, mem_addr);
    end
    step(); branch_valid = 0;
    checks++;
    if (instr_valid !== 1'b0) begin errors++; $display("FAIL branch_drop_pc7: v=%b pc=%0h want v=0", instr_valid, instr_pc); end
    step();
    checks++;
    if ({instr_valid, instr_pc, instr_data} !== {1'b1, 10'h200, 14'h300}) begin
      errors++; $display("FAIL branch_first: v=%b pc=%0h d=%0h want 1/200/300", instr_valid, instr_pc, instr_data);
    end
    step();
    checks++;
    if ({instr_valid, instr_pc, instr_data} !== {1'b1, 10'h201, 14'h301}) begin
      errors++; $display("FAIL branch_next: v=%b pc=%0h d=%0h want 1/201/301", instr_valid, instr_pc, instr_data);
    end
  endtask

  task automatic test_back_to_back_branch();
    branch_valid = 1; branch_target = 10'h10;
    step(); branch_target = 10'h20;
    checks++;
    if (instr_valid !== 1'b0) begin errors++; $display("FAIL b2b_t1: v=%b want 0", instr_valid); end
    step(); branch_valid = 0;
    checks++;
    if (instr_valid !== 1'b0) begin errors++; $display("FAIL b2b_drop_first: v=%b pc=%0h want v=0", instr_valid, instr_pc); end
    step();
    checks++;
    if ({instr_valid, instr_pc, instr_data} !== {1'b1, 10'h20, 14'h120}) begin
      errors++; $display("FAIL b2b_second: v=%b pc=%0h d=%0h want 1/20/120", instr_valid, instr_pc, instr_data);
    end
  endtask

  task automatic test_wrap();
    logic [9:0]  ep [4] = '{10'd1022, 10'd1023, 10'd0, 10'd1};
    logic [13:0] ed [4] = '{14'h4FE, 14'h4FF, 14'h100, 14'h101};
    branch_valid = 1; branch_target = 10'd1022;
    step(); branch_valid = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if ({instr_valid, instr_pc, instr_data} !== {1'b1, ep[k], ed[k]}) begin
        errors++; $display("FAIL wrap_%0d: v=%b pc=%0h d=%0h want 1/%0h/%0h", k, instr_valid, instr_pc, instr_data, ep[k], ed[k]);
      end
    end
  endtask

  task automatic test_fetch_en();
    branch_valid = 1; branch_target = 10'h40;
    step(); branch_valid = 0;
    step();
    checks++;
    if ({instr_valid, instr_pc} !== {1'b1, 10'h40}) begin
      errors++; $display("FAIL fen_first: v=%b pc=%0h want 1/40", instr_valid, instr_pc);
    end
    fetch_en = 0; #1;
    checks++;
    if (mem_rd_en !== 1'b0) begin errors++; $display("FAIL fen_no_issue: rd=%b want 0", mem_rd_en); end
    step();
    checks++;
    if ({instr_valid, instr_pc, instr_data} !== {1'b1, 10'h41, 14'h141}) begin
      errors++; $display("FAIL fen_drain: v=%b pc=%0h d=%0h want 1/41/141", instr_valid, instr_pc, instr_data);
    end
    step();
    checks++;
    if (instr_valid !== 1'b0) begin errors++; $display("FAIL fen_idle: v=%b want 0", instr_valid); end
    step();
    checks++;
    if ({instr_valid, mem_rd_en} !== 2'b00) begin errors++; $display("FAIL fen_idle2: v=%b rd=%b want 0/0", instr_valid, mem_rd_en); end
    fetch_en = 1; #1;
    checks++;
    if ({mem_rd_en, mem_addr} !== {1'b1, 10'h42}) begin
      errors++; $display("FAIL fen_resume: rd=%b addr=%0h want 1/42", mem_rd_en, mem_addr);
    end
    step(); step();
    checks++;
    if ({instr_valid, instr_pc, instr_data} !== {1'b1, 10'h42, 14'h142}) begin
      errors++; $display("FAIL fen_resume_word: v=%b pc=%0h d=%0h want 1/42/142", instr_valid, instr_pc, instr_data);
    end
  endtask

  task automatic test_reset_midop();
    branch_valid = 1; branch_target = 10'h80;
    step(); branch_valid = 0;
    step(); instr_ready = 0;
    step();
    checks++;
    if ({instr_valid, instr_pc, instr_data, dut.skid_valid} !== {1'b1, 10'h80, 14'h180, 1'b1}) begin
      errors++; $display("FAIL midop_full: v=%b pc=%0h d=%0h skid=%b want 1/80/180/1", instr_valid, instr_pc, instr_data, dut.skid_valid);
    end
    #2; irst = 0; #1;
    checks++;
    if ({instr_valid, instr_pc, instr_data, mem_rd_en} !== {1'b0, 10'd0, 14'd0, 1'b0}) begin
      errors++; $display("FAIL midop_async_clear: v=%b pc=%0h d=%0h rd=%b want 0", instr_valid, instr_pc, instr_data, mem_rd_en);
    end
    instr_ready = 1;
    step(); step();
    @(negedge iclk); irst = 1;
    step();
    checks++;
    if ({mem_rd_en, mem_addr} !== {1'b1, 10'd0}) begin
      errors++; $display("FAIL midop_restart_issue: rd=%b addr=%0h want 1/0", mem_rd_en, mem_addr);
    end
    step();
    checks++;
    if (instr_valid !== 1'b0) begin errors++; $display("FAIL midop_no_stale: v=%b pc=%0h want v=0", instr_valid, instr_pc); end
    step();
    checks++;
    if ({instr_valid, instr_pc, instr_data} !== {1'b1, 10'd0, 14'h100}) begin
      errors++; $display("FAIL midop_first: v=%b pc=%0h d=%0h want 1/0/100", instr_valid, instr_pc, instr_data);
    end
  endtask

`ifdef FETCH_PERF_CNT_EN
  task automatic test_perf();
    int acc; bit found;
    irst = 0; instr_ready = 0; fetch_en = 1; branch_valid = 0;
    step(); step();
    checks++;
    if ({fetch_cnt, stall_cnt} !== 64'd0) begin
      errors++; $display("FAIL perf_reset: fetch=%0d stall=%0d want 0/0", fetch_cnt, stall_cnt);
    end
    @(negedge iclk); irst = 1;
    found = 0;
    for (int n = 0; n < 10 && !found; n++) begin
      if (instr_valid) found = 1; else step();
    end
    checks++;
    if (!found) begin errors++; $display("FAIL perf_first_valid: v=%b want 1", instr_valid); end
    step(); step(); step();
    instr_ready = 1;
    acc = 0;
    for (int n = 0; n < 60 && acc < 10; n++) begin
      if (instr_valid) acc++;
      step();
    end
    checks++;
    if (fetch_cnt !== 32'd10 || stall_cnt !== 32'd3) begin
      errors++; $display("FAIL perf_counts: fetch=%0d stall=%0d want 10/3", fetch_cnt, stall_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_branch();
    test_back_to_back_branch();
    test_wrap();
    test_fetch_en();
    test_reset_midop();
`ifdef FETCH_PERF_CNT_EN
    test_perf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Program-counter fetch stage that sits directly upstream and downstream of the 1024x14 program memory.
- Drives the memory address and read enable, then captures the 14-bit word one cycle later.
- Presents fetched instructions to the decoder over a valid/ready handshake.
- Absorbs decoder back-pressure with a one-entry skid buffer; supports branch redirect with flush of stale words.

Parameters:
ADDR_W, 10, program memory address width; PC width
DATA_W, 14, instruction width
RESET_PC, 0, PC value loaded at reset

Ports:
iclk  input  1  system clock, all state on rising edge
irst  input  1  asynchronous active-low reset
fetch_en  input  1  1 = fetch may issue new reads; 0 = no new issue, in-flight word still completes
mem_addr  output  ADDR_W  address to program memory; combinational: branch_valid ? branch_target : pc_q
mem_rd_en  output  1  read request this cycle (= issue)
mem_rdata  input  DATA_W  memory read data, registered by memory, valid the cycle after issue
branch_valid  input  1  redirect request, single-cycle pulse
branch_target  input  ADDR_W  redirect destination
instr_valid  output  1  instruction output valid
instr_ready  input  1  decoder accepts instruction
instr_data  output  DATA_W  fetched instruction
instr_pc  output  ADDR_W  address of instr_data

Behaviour:
- Reset (irst=0, async):
  - pc_q=RESET_PC; run_q=0; req_q=0; req_pc_q=0; skid_valid=0; skid_data=0; skid_pc=0.
  - instr_valid=0, instr_data=0, instr_pc=0, mem_rd_en=0.
- run_q is set on the first clock edge after reset release, so no read issues in the first cycle after deassertion.
- Issue condition:
  - issue = run_q & fetch_en & ~skid_valid & ~(req_q & instr_valid & ~instr_ready) & ~branch_valid, OR issue = run_q & branch_valid.
  - A redirect always issues, regardless of fetch_en.
- On issue: req_q<=1; req_pc_q<=mem_addr; pc_q<=mem_addr+1, wrapping modulo 2^ADDR_W (1023 -> 0). Otherwise req_q<=0 and pc_q holds.
- Arrival: when req_q=1, mem_rdata/req_pc_q is the returning word.
  - If the output is empty or being consumed (~instr_valid | instr_ready) and the skid is empty, the word loads the output register.
  - If the output is stalled, the word loads the skid.
  - If the skid is valid and the output is consumed, the skid moves to the output and the arriving word goes to the skid.
  - Order is strictly preserved.
- Output register: instr_valid clears on handshake (instr_valid & instr_ready) unless it is refilled that cycle. instr_data/instr_pc are stable while instr_valid & ~instr_ready.
- Latency: issue in cycle t -> instr_valid in cycle t+2 with no stall. Sustained throughput is 1 instruction/cycle with instr_ready held high.
- Redirect (branch_valid=1 in cycle t):
  - The in-flight word (req_q) is discarded.
  - skid_valid<=0 and instr_valid<=0 at the end of t; any handshake in cycle t still counts as consumed.
  - The target is issued in t, with first target instr_valid in t+2.
  - A second branch_valid in t+1 supersedes the first; the word from the first target is discarded.
- fetch_en low mid-stream: no new issue; the outstanding word is delivered; pc_q holds; re-enabling resumes at pc_q.
- Skid overflow is impossible by construction. The bench asserts: never (req_q & skid_valid & instr_valid & ~instr_ready & ~branch_valid).
- Reset mid-operation clears everything asynchronously. After release, fetch restarts from RESET_PC; no pre-reset word is ever presented.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined: adds output ports fetch_cnt [31:0] and stall_cnt [31:0], both reset to 0 and both wrapping at 2^32.
  - fetch_cnt increments on every instr_valid & instr_ready.
  - stall_cnt increments on every cycle with instr_valid & ~instr_ready.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset release with fetch_en=1, instr_ready=1, memory preloaded mem[k]=k+0x100 -> first instr_valid 2 cycles after the first mem_rd_en; instr_pc 0,1,2... every cycle; instr_data 0x100,0x101,...
- instr_ready=0 for 5 cycles mid-stream at pc 4 -> instr_data=0x104 held; at most one extra word in the skid; on release 0x104,0x105,0x106 in order with no gap or duplicate.
- branch_valid pulse with target 0x200 while a word from pc 7 is in flight -> the pc 7 word is never presented; next instr_pc=0x200, instr_data=mem[0x200], 2 cycles after the pulse.
- Fetch running from pc 1022 -> instr_pc 1022, 1023, 0, 1 (wrap).
- irst asserted while skid full and output stalled -> instr_valid=0 immediately (async); after release, first instr_pc=RESET_PC.
- With FETCH_PERF_CNT_EN, 10 accepted and 3 stalled cycles -> fetch_cnt=10, stall_cnt=3.
